// File: rtl/fp32_to_int_pipeline.sv
// fp32_to_int_pipeline: two-stage binary32 to signed int32 converter with valid/ready stall
module fp32_to_int_pipeline #(
  parameter int ROUND_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        Invalid,
  output logic        Overflow,
  output logic        Inexact
);
  localparam logic [1:0] C_NORM = 2'd0;
  localparam logic [1:0] C_ZERO = 2'd1;
  localparam logic [1:0] C_INF  = 2'd2;
  localparam logic [1:0] C_NAN  = 2'd3;
  logic              w_stall;
  logic [7:0]        w_exp;
  logic [22:0]       w_frac;
  logic [1:0]        w_cls;
  logic [23:0]       w_m;
  logic signed [8:0] w_e;
  logic              r1_valid;
  logic              r1_sign;
  logic [1:0]        r1_cls;
  logic [23:0]       r1_m;
  logic signed [8:0] r1_e;
  logic              r_out_valid;
  logic [31:0]       r_result;
  logic              r_inv;
  logic              r_ovf;
  logic              r_inx;
  logic              w_frac_nz;
  logic              w_low;
  logic [5:0]        w_sh;
  logic [2:0]        w_shl;
  logic [47:0]       w_shr;
  logic [23:0]       w_int;
  logic              w_guard;
  logic              w_sticky;
  logic              w_inc;
  logic [31:0]       w_rnd;
  logic [31:0]       w_big;
  logic [31:0]       w_mag;
  logic [31:0]       w_sat;
  logic              w_min;
  logic [31:0]       w_res;
  logic              w_inv;
  logic              w_ovf;
  logic              w_inx;
  assign w_stall   = r_out_valid & ~out_ready;
  assign in_ready  = ~rst | ~w_stall;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign Invalid   = r_inv;
  assign Overflow  = r_ovf;
  assign Inexact   = r_inx;
  assign w_exp  = fp_in[30:23];
  assign w_frac = fp_in[22:0];
  assign w_cls  = (w_exp == 8'hff) ? ((|w_frac) ? C_NAN : C_INF) : (w_exp == 8'h00) ? C_ZERO : C_NORM;
  // the hidden bit doubles as the denormal marker, so |m[22:0] is always F!=0
  assign w_m = {|w_exp, w_frac};
  assign w_e = $signed({1'b0, w_exp}) - 9'sd127;
  assign w_frac_nz = |r1_m[22:0];
  assign w_low     = r1_e < -9'sd1;
  assign w_sh      = 6'(9'sd23 - r1_e);
  assign w_shl     = 3'(r1_e - 9'sd23);
  // for -1 <= e <= 22 the upper half is the integer part, bit 23 the guard, the rest sticky
  assign w_shr    = {r1_m, 24'b0} >> w_sh;
  assign w_int    = w_low ? 24'd0 : w_shr[47:24];
  assign w_guard  = w_low ? 1'b0 : w_shr[23];
  assign w_sticky = w_low ? 1'b1 : |w_shr[22:0];
  assign w_inc    = (ROUND_MODE == 0) && w_guard && (w_sticky || w_int[0]);
  assign w_rnd    = {8'b0, w_int} + {31'b0, w_inc};
  assign w_big    = {8'b0, r1_m} << w_shl;
  assign w_mag    = (r1_e >= 9'sd23) ? w_big : w_rnd;
  assign w_sat    = r1_sign ? 32'h8000_0000 : 32'h7fff_ffff;
  assign w_min    = r1_sign && (r1_e == 9'sd31) && !w_frac_nz;
  always_comb begin
    w_res = r1_sign ? -w_mag : w_mag;
    w_inv = 1'b0;
    w_ovf = 1'b0;
    w_inx = (r1_e < 9'sd23) && (w_guard || w_sticky);
    if (r1_cls == C_NAN) begin
      w_res = 32'h8000_0000;
      w_inv = 1'b1;
      w_inx = 1'b0;
    end else if (r1_cls == C_INF) begin
      w_res = w_sat;
      w_inv = 1'b1;
      w_inx = 1'b0;
    end else if (r1_cls == C_ZERO) begin
      w_res = 32'h0;
      w_inx = w_frac_nz;
    end else if (r1_e >= 9'sd31) begin
      w_res = w_min ? 32'h8000_0000 : w_sat;
      w_ovf = !w_min;
      w_inx = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r1_valid    <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_inv       <= 1'b0;
      r_ovf       <= 1'b0;
      r_inx       <= 1'b0;
    end else if (!w_stall) begin
      r1_valid    <= in_valid;
      r1_sign     <= fp_in[31];
      r1_cls      <= w_cls;
      r1_m        <= w_m;
      r1_e        <= w_e;
      r_out_valid <= r1_valid;
      r_result    <= r1_valid ? w_res : '0;
      r_inv       <= r1_valid & w_inv;
      r_ovf       <= r1_valid & w_ovf;
      r_inx       <= r1_valid & w_inx;
    end
  end
endmodule

// File: tb/tb_fp32_to_int_pipeline.sv
// tb_fp32_to_int_pipeline: scoreboard bench running round-to-nearest and truncating instances side by side
module tb_fp32_to_int_pipeline;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] fp_in = '0;
  logic        in_ready0, out_valid0, inv0, ovf0, inx0;
  logic        in_ready1, out_valid1, inv1, ovf1, inx1;
  logic [31:0] res0, res1;
  logic [34:0] x0, x1;
  logic [34:0] q0[$];
  logic [34:0] q1[$];
  int          qc[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        chk_lat = 1'b1;

  fp32_to_int_pipeline #(.ROUND_MODE(0)) u_rne (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .fp_in(fp_in),
    .out_valid(out_valid0), .out_ready(out_ready), .result(res0),
    .Invalid(inv0), .Overflow(ovf0), .Inexact(inx0));
  fp32_to_int_pipeline #(.ROUND_MODE(1)) u_trc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .fp_in(fp_in),
    .out_valid(out_valid1), .out_ready(out_ready), .result(res1),
    .Invalid(inv1), .Overflow(ovf1), .Inexact(inx1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference: exact remainder-vs-half comparison; returns {Invalid, Overflow, Inexact, result}
  function automatic logic [34:0] ref_conv(input logic [31:0] f, input int mode);
    logic s = f[31];
    int e = int'(f[30:23]);
    logic [63:0] m = {40'b0, 1'b1, f[22:0]};
    logic [63:0] ip, rem, half;
    logic inx = 1'b0;
    logic up = 1'b0;
    int k;
    if (e == 255) return {3'b100, (f[22:0] != 0 || s) ? 32'h8000_0000 : 32'h7fff_ffff};
    if (e == 0) return {2'b00, f[22:0] != 0, 32'h0};
    if (e >= 158) begin
      if (s && e == 158 && f[22:0] == 0) return {3'b000, 32'h8000_0000};
      return {3'b010, s ? 32'h8000_0000 : 32'h7fff_ffff};
    end
    if (e >= 150) ip = m << (e - 150);
    else begin
      k = 150 - e;
      if (k >= 40) begin
        ip = 0;
        inx = 1'b1;
      end else begin
        ip = m >> k;
        rem = m & ((64'd1 << k) - 64'd1);
        half = 64'd1 << (k - 1);
        inx = rem != 0;
        up = mode == 0 && (rem > half || (rem == half && ip[0]));
      end
    end
    ip = ip + {63'b0, up};
    return {2'b00, inx, s ? -ip[31:0] : ip[31:0]};
  endfunction

  always @(negedge clk) begin
    logic [34:0] ev;
    int c;
    if (rst) begin
      if (in_valid && in_ready0) begin
        q0.push_back(x0);
        q1.push_back(x1);
        qc.push_back(cyc);
      end
      if (out_valid0 && out_ready) begin
        n_vec++;
        if (q0.size() == 0) begin
          n_err++;
          $display("FAIL rne_extra: got %h with nothing outstanding", res0);
        end else begin
          ev = q0.pop_front();
          c = qc.pop_front();
          if ({inv0, ovf0, inx0, res0} !== ev) begin
            n_err++;
            $display("FAIL rne_result: got flags %b result %h, want flags %b result %h",
                     {inv0, ovf0, inx0}, res0, ev[34:32], ev[31:0]);
          end
          if (chk_lat && cyc - c != 2) begin
            n_err++;
            $display("FAIL rne_latency: got %0d cycles, want 2", cyc - c);
          end
        end
      end
      if (out_valid1 && out_ready) begin
        n_vec++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL trc_extra: got %h with nothing outstanding", res1);
        end else begin
          ev = q1.pop_front();
          if ({inv1, ovf1, inx1, res1} !== ev) begin
            n_err++;
            $display("FAIL trc_result: got flags %b result %h, want flags %b result %h",
                     {inv1, ovf1, inx1}, res1, ev[34:32], ev[31:0]);
          end
        end
      end
      if (!out_valid0 && {inv0, ovf0, inx0, inv1, ovf1, inx1} !== 6'b0) begin
        n_vec++;
        n_err++;
        $display("FAIL idle_flags: got %b, want 000000", {inv0, ovf0, inx0, inv1, ovf1, inx1});
      end
    end
  end

  task automatic send(input logic [31:0] f, input logic [34:0] e0, input logic [34:0] e1);
    int t = 0;
    fp_in = f;
    x0 = e0;
    x1 = e1;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready0 && t < 100) begin
      t++;
      @(negedge clk);
    end
    n_vec++;
    if (!in_ready0) begin
      n_err++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", in_ready0, t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic same(input logic [31:0] f, input logic [34:0] e);
    send(f, e, e);
  endtask

  task automatic drain;
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
      t++;
      @(negedge clk);
    end
    n_vec++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d results outstanding, want 0", q0.size(), q1.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({in_ready0, out_valid0, res0, inv0, ovf0, inx0} !== {1'b1, 1'b0, 32'h0, 3'b0} ||
        {in_ready1, out_valid1, res1, inv1, ovf1, inx1} !== {1'b1, 1'b0, 32'h0, 3'b0}) begin
      n_err++;
      $display("FAIL reset_state: got rdy %b%b vld %b%b res %h %h flags %b%b%b, want rdy 11 vld 00 res 0 flags 0",
               in_ready0, in_ready1, out_valid0, out_valid1, res0, res1, inv0, ovf0, inx0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_rounding;
    chk_lat = 1'b1;
    send(32'h3FC0_0000, {3'b001, 32'd2}, {3'b001, 32'd1});
    drain();
    send(32'h4020_0000, {3'b001, 32'd2}, {3'b001, 32'd2});
    drain();
    send(32'h3F00_0000, {3'b001, 32'd0}, {3'b001, 32'd0});
    drain();
    send(32'h3F40_0000, {3'b001, 32'd1}, {3'b001, 32'd0});
    drain();
  endtask

  task automatic test_truncation;
    same(32'hC2F6_E979, {3'b001, 32'hFFFF_FF85});
    same(32'h4B00_0001, {3'b000, 32'h0080_0001});
    send(32'hBFC0_0000, {3'b001, 32'hFFFF_FFFE}, {3'b001, 32'hFFFF_FFFF});
    drain();
  endtask

  task automatic test_range;
    same(32'hCF00_0000, {3'b000, 32'h8000_0000});
    same(32'h4F00_0000, {3'b010, 32'h7FFF_FFFF});
    same(32'hDF00_0000, {3'b010, 32'h8000_0000});
    same(32'h4EFF_FFFF, {3'b000, 32'h7FFF_FF80});
    same(32'hCF00_0001, {3'b010, 32'h8000_0000});
    drain();
  endtask

  task automatic test_specials;
    same(32'h7FC0_0000, {3'b100, 32'h8000_0000});
    same(32'h7F80_0000, {3'b100, 32'h7FFF_FFFF});
    same(32'hFF80_0000, {3'b100, 32'h8000_0000});
    same(32'h0000_0001, {3'b001, 32'h0});
    same(32'h8000_0000, {3'b000, 32'h0});
    same(32'h0000_0000, {3'b000, 32'h0});
    drain();
  endtask

  task automatic test_back_to_back;
    logic [31:0] f;
    for (int i = 0; i < 40; i++) begin
      f = {1'($urandom), 8'($urandom_range(100, 165)), 23'($urandom)};
      send(f, ref_conv(f, 0), ref_conv(f, 1));
    end
    drain();
  endtask

  task automatic test_backpressure;
    logic [31:0] ops[5] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
    chk_lat = 1'b0;
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 5; i++) same(ops[i], {3'b000, 32'(i + 1)});
      begin
        int t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!out_valid0 && t < 20);
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clk);
          n_vec++;
          if ({out_valid0, in_ready0, res0, inv0, ovf0, inx0} !== {1'b1, 1'b0, 32'h1, 3'b0}) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: got vld %b rdy %b res %h, want vld 1 rdy 0 res 00000001",
                     i, out_valid0, in_ready0, res0);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_random_backpressure;
    logic done = 1'b0;
    chk_lat = 1'b0;
    fork
      begin
        logic [31:0] f;
        for (int i = 0; i < 30; i++) begin
          f = (i % 5 == 0) ? $urandom : {1'($urandom), 8'($urandom_range(110, 160)), 23'($urandom)};
          send(f, ref_conv(f, 0), ref_conv(f, 1));
        end
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk);
        #1;
        out_ready = $urandom_range(0, 3) != 0;
      end
    join
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid;
    chk_lat = 1'b0;
    out_ready = 1'b0;
    same(32'h3F80_0000, {3'b000, 32'd1});
    same(32'h4000_0000, {3'b000, 32'd2});
    rst = 1'b0;
    q0.delete();
    q1.delete();
    qc.delete();
    @(negedge clk);
    n_vec++;
    if ({in_ready0, in_ready1} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b, want 11", {in_ready0, in_ready1});
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({out_valid0, res0, inv0, ovf0, inx0, out_valid1, res1, inv1, ovf1, inx1} !== 72'b0) begin
      n_err++;
      $display("FAIL reset_flush: got vld %b%b res %h %h, want all zero", out_valid0, out_valid1, res0, res1);
    end
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    chk_lat = 1'b1;
    same(32'h4120_0000, {3'b000, 32'h0000_000A});
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rounding();
    test_truncation();
    test_range();
    test_specials();
    test_back_to_back();
    test_backpressure();
    test_random_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
